// File: rtl/adc_acq_pkg.sv
// ---------------------------------------------------------------------------
// adc_acq_pkg
//   Shared constants and helpers for the ADC acquisition statistics blocks.
//   - DATA_W_DEF : default sample width (signed two's complement)
//   - smax_init  : most positive signed value of a given width, i.e. the
//                  start value of a running minimum
//   - smin_init  : most negative signed value of a given width, i.e. the
//                  start value of a running maximum
//   Both helpers return a 32-bit pattern; callers keep the low w bits.
// ---------------------------------------------------------------------------
package adc_acq_pkg;

    localparam int DATA_W_DEF = 16;

    // 2^(w-1)-1
    function automatic logic [31:0] smax_init(input int w);
        return (32'd1 << (w - 1)) - 32'd1;
    endfunction

    // -2^(w-1), sign-extended to 32 bits
    function automatic logic [31:0] smin_init(input int w);
        return ~((32'd1 << (w - 1)) - 32'd1);
    endfunction

endpackage

// File: rtl/adc_ch_stats.sv
// ---------------------------------------------------------------------------
// adc_ch_stats
//   Running max / min / sum of one ADC channel over the current window.
//   Ports:
//     clk_i       : clock, rising edge
//     rst_i       : synchronous active-high reset
//     sample_i    : signed sample for this channel
//     valid_i     : sample_i is valid this cycle
//     restart_i   : discard the partial window
//     done_i      : this valid beat is the last beat of the window
//     fin_max_o   : running max including sample_i (used by the top on done_i)
//     fin_min_o   : running min including sample_i
//     fin_sum_o   : running sum including sample_i
// ---------------------------------------------------------------------------
module adc_ch_stats
    import adc_acq_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int WIN_LOG2 = 10
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic signed [DATA_W-1:0]         sample_i,
    input  logic                             valid_i,
    input  logic                             restart_i,
    input  logic                             done_i,
    output logic signed [DATA_W-1:0]         fin_max_o,
    output logic signed [DATA_W-1:0]         fin_min_o,
    output logic signed [DATA_W+WIN_LOG2-1:0] fin_sum_o
);

    localparam int SUM_W = DATA_W + WIN_LOG2;

    localparam logic [31:0] MAX_INIT_32 = smin_init(DATA_W);
    localparam logic [31:0] MIN_INIT_32 = smax_init(DATA_W);
    localparam logic signed [DATA_W-1:0] MAX_INIT = MAX_INIT_32[DATA_W-1:0];
    localparam logic signed [DATA_W-1:0] MIN_INIT = MIN_INIT_32[DATA_W-1:0];

    logic signed [DATA_W-1:0] max_q, max_d;
    logic signed [DATA_W-1:0] min_q, min_d;
    logic signed [SUM_W-1:0]  sum_q, sum_d;

    logic signed [DATA_W-1:0] base_max, base_min;
    logic signed [SUM_W-1:0]  base_sum;
    logic signed [DATA_W-1:0] upd_max, upd_min;
    logic signed [SUM_W-1:0]  upd_sum;

    always_comb begin
        // A restart throws the partial window away, so a sample arriving with
        // it accumulates onto fresh initial values. On the completion beat the
        // sample still belongs to the old window, so done_i wins.
        if (restart_i && !done_i) begin
            base_max = MAX_INIT;
            base_min = MIN_INIT;
            base_sum = '0;
        end else begin
            base_max = max_q;
            base_min = min_q;
            base_sum = sum_q;
        end

        upd_max = (sample_i > base_max) ? sample_i : base_max;
        upd_min = (sample_i < base_min) ? sample_i : base_min;
        upd_sum = base_sum + {{WIN_LOG2{sample_i[DATA_W-1]}}, sample_i};

        max_d = max_q;
        min_d = min_q;
        sum_d = sum_q;
        if (done_i) begin
            max_d = MAX_INIT;
            min_d = MIN_INIT;
            sum_d = '0;
        end else if (valid_i) begin
            max_d = upd_max;
            min_d = upd_min;
            sum_d = upd_sum;
        end else if (restart_i) begin
            max_d = MAX_INIT;
            min_d = MIN_INIT;
            sum_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            max_q <= MAX_INIT;
            min_q <= MIN_INIT;
            sum_q <= '0;
        end else begin
            max_q <= max_d;
            min_q <= min_d;
            sum_q <= sum_d;
        end
    end

    assign fin_max_o = upd_max;
    assign fin_min_o = upd_min;
    assign fin_sum_o = upd_sum;

endmodule

// File: rtl/adc_window_stats.sv
// ---------------------------------------------------------------------------
// adc_window_stats
//   Per-channel window statistics over 2^WIN_LOG2 valid ADC beats. At the end
//   of each window the max, min, mid-range, peak-to-peak and mean of every
//   channel are loaded into output registers and offered with a valid/ready
//   handshake. An unaccepted result set that gets overwritten sets a sticky
//   Overrun flag.
//   Ports:
//     Clk          : clock, rising edge
//     Rst          : synchronous active-high reset
//     ADC_IN       : packed samples, channel n at [n*DATA_W +: DATA_W]
//     Data_Valid   : ADC_IN valid for all channels
//     Win_Restart  : discard the partial window, start a new one
//     VMax/VMin    : signed window max / min per channel
//     VMid         : floor((VMax+VMin)/2) per channel
//     VMean        : floor(sum / 2^WIN_LOG2) per channel
//     VPP          : unsigned VMax-VMin per channel, DATA_W+1 bits each
//     Stat_Valid   : result set available
//     Stat_Ready   : consumer accepts the result set
//     Overrun      : sticky, a result set was overwritten before acceptance
// ---------------------------------------------------------------------------
module adc_window_stats
    import adc_acq_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int CH_NUM   = 2,
    parameter int WIN_LOG2 = 10
) (
    input  logic                       Clk,
    input  logic                       Rst,
    input  logic [CH_NUM*DATA_W-1:0]   ADC_IN,
    input  logic                       Data_Valid,
    input  logic                       Win_Restart,
    output logic [CH_NUM*DATA_W-1:0]   VMax,
    output logic [CH_NUM*DATA_W-1:0]   VMin,
    output logic [CH_NUM*DATA_W-1:0]   VMid,
    output logic [CH_NUM*DATA_W-1:0]   VMean,
    output logic [CH_NUM*(DATA_W+1)-1:0] VPP,
    output logic                       Stat_Valid,
    input  logic                       Stat_Ready,
    output logic                       Overrun
);

    localparam int SUM_W = DATA_W + WIN_LOG2;
    localparam logic [WIN_LOG2-1:0] CNT_LAST = '1;

    logic [WIN_LOG2-1:0] cnt_q, cnt_d;
    logic                done;

    logic [DATA_W-1:0]   ch_max  [CH_NUM];
    logic [DATA_W-1:0]   ch_min  [CH_NUM];
    logic [DATA_W-1:0]   ch_mid  [CH_NUM];
    logic [DATA_W-1:0]   ch_mean [CH_NUM];
    logic [DATA_W:0]     ch_vpp  [CH_NUM];

    logic [CH_NUM*DATA_W-1:0]     vmax_d, vmin_d, vmid_d, vmean_d;
    logic [CH_NUM*(DATA_W+1)-1:0] vpp_d;
    logic [CH_NUM*DATA_W-1:0]     vmax_q, vmin_q, vmid_q, vmean_q;
    logic [CH_NUM*(DATA_W+1)-1:0] vpp_q;
    logic                         stat_valid_q, stat_valid_d;
    logic                         overrun_q, overrun_d;

    // Completion beat: the valid beat that fills the last slot of the window.
    assign done = Data_Valid && (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (done) begin
            cnt_d = '0;
        end else if (Data_Valid) begin
            cnt_d = Win_Restart ? WIN_LOG2'(1) : cnt_q + WIN_LOG2'(1);
        end else if (Win_Restart) begin
            cnt_d = '0;
        end
    end

    for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
        logic signed [DATA_W-1:0] fmax, fmin;
        logic signed [SUM_W-1:0]  fsum;
        logic signed [DATA_W:0]   ext_max, ext_min, mid_sum;
        logic                     unused_lsbs;

        adc_ch_stats #(
            .DATA_W   (DATA_W),
            .WIN_LOG2 (WIN_LOG2)
        ) u_stats (
            .clk_i     (Clk),
            .rst_i     (Rst),
            .sample_i  (ADC_IN[c*DATA_W +: DATA_W]),
            .valid_i   (Data_Valid),
            .restart_i (Win_Restart),
            .done_i    (done),
            .fin_max_o (fmax),
            .fin_min_o (fmin),
            .fin_sum_o (fsum)
        );

        assign ext_max = {fmax[DATA_W-1], fmax};
        assign ext_min = {fmin[DATA_W-1], fmin};
        assign mid_sum = ext_max + ext_min;

        assign ch_max[c]  = fmax;
        assign ch_min[c]  = fmin;
        // Dropping the LSB of the DATA_W+1 bit sum is the arithmetic shift;
        // the result always fits back into DATA_W bits.
        assign ch_mid[c]  = mid_sum[DATA_W:1];
        assign ch_vpp[c]  = ext_max - ext_min;
        // The sum never exceeds DATA_W+WIN_LOG2 bits, so its top DATA_W bits
        // are exactly the floored mean.
        assign ch_mean[c] = fsum[WIN_LOG2 +: DATA_W];

        assign unused_lsbs = ^{mid_sum[0], fsum[WIN_LOG2-1:0]};
    end

    always_comb begin
        vmax_d  = '0;
        vmin_d  = '0;
        vmid_d  = '0;
        vmean_d = '0;
        vpp_d   = '0;
        for (int c = 0; c < CH_NUM; c++) begin
            vmax_d[c*DATA_W +: DATA_W]     = ch_max[c];
            vmin_d[c*DATA_W +: DATA_W]     = ch_min[c];
            vmid_d[c*DATA_W +: DATA_W]     = ch_mid[c];
            vmean_d[c*DATA_W +: DATA_W]    = ch_mean[c];
            vpp_d[c*(DATA_W+1) +: DATA_W+1] = ch_vpp[c];
        end
    end

    // A load on the same cycle as an acceptance keeps Stat_Valid high with the
    // new set; a load without acceptance of a pending set is an overrun.
    always_comb begin
        stat_valid_d = stat_valid_q;
        overrun_d    = overrun_q;
        if (done) begin
            stat_valid_d = 1'b1;
            if (stat_valid_q && !Stat_Ready) begin
                overrun_d = 1'b1;
            end
        end else if (Stat_Ready) begin
            stat_valid_d = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            cnt_q        <= '0;
            vmax_q       <= '0;
            vmin_q       <= '0;
            vmid_q       <= '0;
            vmean_q      <= '0;
            vpp_q        <= '0;
            stat_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            stat_valid_q <= stat_valid_d;
            overrun_q    <= overrun_d;
            if (done) begin
                vmax_q  <= vmax_d;
                vmin_q  <= vmin_d;
                vmid_q  <= vmid_d;
                vmean_q <= vmean_d;
                vpp_q   <= vpp_d;
            end
        end
    end

    assign VMax       = vmax_q;
    assign VMin       = vmin_q;
    assign VMid       = vmid_q;
    assign VMean      = vmean_q;
    assign VPP        = vpp_q;
    assign Stat_Valid = stat_valid_q;
    assign Overrun    = overrun_q;

endmodule

// File: tb/tb_adc_window_stats.sv
// ---------------------------------------------------------------------------
// tb_adc_window_stats
//   Bench for adc_window_stats with DATA_W=16, CH_NUM=2, WIN_LOG2=2.
//   Stimulus is applied on the falling edge; a reference model of the window
//   statistics pushes expected result sets into a queue, and a monitor pops
//   and compares them one cycle after each completion beat. Between loads the
//   monitor checks that the outputs hold the last result set.
// ---------------------------------------------------------------------------
module tb_adc_window_stats;

    localparam int DW = 16;
    localparam int CH = 2;
    localparam int WL = 2;

    logic              Clk = 1'b0;
    logic              Rst = 1'b1;
    logic [CH*DW-1:0]  ADC_IN = '0;
    logic              Data_Valid = 1'b0;
    logic              Win_Restart = 1'b0;
    logic              Stat_Ready = 1'b0;
    logic [CH*DW-1:0]  VMax, VMin, VMid, VMean;
    logic [CH*(DW+1)-1:0] VPP;
    logic              Stat_Valid, Overrun;

    adc_window_stats #(.DATA_W(DW), .CH_NUM(CH), .WIN_LOG2(WL)) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .ADC_IN     (ADC_IN),
        .Data_Valid (Data_Valid),
        .Win_Restart(Win_Restart),
        .VMax       (VMax),
        .VMin       (VMin),
        .VMid       (VMid),
        .VMean      (VMean),
        .VPP        (VPP),
        .Stat_Valid (Stat_Valid),
        .Stat_Ready (Stat_Ready),
        .Overrun    (Overrun)
    );

    always #5 Clk = ~Clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int vmax;
        int vmin;
        int vmid;
        int vpp;
        int vmean;
    } res_t;

    res_t exp_q[$];
    res_t hold_r[CH];

    int   m_cnt;
    int   m_mx[CH];
    int   m_mn[CH];
    int   m_sm[CH];
    bit   m_sv;
    bit   m_ov;
    bit   mon_en = 1'b0;

    function automatic void m_clear();
        m_cnt = 0;
        for (int c = 0; c < CH; c++) begin
            m_mx[c] = -32768;
            m_mn[c] = 32767;
            m_sm[c] = 0;
        end
    endfunction

    function automatic void m_add(input int c, input int s);
        if (s > m_mx[c]) m_mx[c] = s;
        if (s < m_mn[c]) m_mn[c] = s;
        m_sm[c] = m_sm[c] + s;
    endfunction

    // One clock of stimulus; the model is advanced to the state the DUT will
    // have after the coming rising edge.
    task automatic drive(input int a, input int b, input bit dv, input bit rs, input bit rdy);
        int   s[CH];
        bit   done;
        res_t r;
        @(negedge Clk);
        ADC_IN      = {16'(b), 16'(a)};
        Data_Valid  = dv;
        Win_Restart = rs;
        Stat_Ready  = rdy;
        s[0] = a;
        s[1] = b;
        done = dv && (m_cnt == (1 << WL) - 1);
        if (done) begin
            for (int c = 0; c < CH; c++) begin
                m_add(c, s[c]);
                r.vmax  = m_mx[c];
                r.vmin  = m_mn[c];
                r.vmid  = (m_mx[c] + m_mn[c]) >>> 1;
                r.vpp   = m_mx[c] - m_mn[c];
                r.vmean = m_sm[c] >>> WL;
                exp_q.push_back(r);
            end
            m_clear();
            if (m_sv && !rdy) m_ov = 1'b1;
            m_sv = 1'b1;
        end else begin
            if (rs) m_clear();
            if (dv) begin
                for (int c = 0; c < CH; c++) m_add(c, s[c]);
                m_cnt++;
            end
            if (rdy) m_sv = 1'b0;
        end
    endtask

    // Scoreboard consumer.
    initial begin
        int g;
        forever begin
            @(posedge Clk);
            #1;
            if (mon_en && !Rst) begin
                if (exp_q.size() >= CH) begin
                    for (int c = 0; c < CH; c++) hold_r[c] = exp_q.pop_front();
                end
                checks++;
                if (Stat_Valid !== m_sv) begin
                    failures++;
                    $display("FAIL mon_stat_valid t=%0t got %0b exp %0b", $time, Stat_Valid, m_sv);
                end
                checks++;
                if (Overrun !== m_ov) begin
                    failures++;
                    $display("FAIL mon_overrun t=%0t got %0b exp %0b", $time, Overrun, m_ov);
                end
                for (int c = 0; c < CH; c++) begin
                    g = int'($signed(VMax[c*DW +: DW]));
                    checks++;
                    if (g != hold_r[c].vmax) begin
                        failures++;
                        $display("FAIL mon_vmax ch%0d t=%0t got %0d exp %0d", c, $time, g, hold_r[c].vmax);
                    end
                    g = int'($signed(VMin[c*DW +: DW]));
                    checks++;
                    if (g != hold_r[c].vmin) begin
                        failures++;
                        $display("FAIL mon_vmin ch%0d t=%0t got %0d exp %0d", c, $time, g, hold_r[c].vmin);
                    end
                    g = int'($signed(VMid[c*DW +: DW]));
                    checks++;
                    if (g != hold_r[c].vmid) begin
                        failures++;
                        $display("FAIL mon_vmid ch%0d t=%0t got %0d exp %0d", c, $time, g, hold_r[c].vmid);
                    end
                    g = int'(VPP[c*(DW+1) +: DW+1]);
                    checks++;
                    if (g != hold_r[c].vpp) begin
                        failures++;
                        $display("FAIL mon_vpp ch%0d t=%0t got %0d exp %0d", c, $time, g, hold_r[c].vpp);
                    end
                    g = int'($signed(VMean[c*DW +: DW]));
                    checks++;
                    if (g != hold_r[c].vmean) begin
                        failures++;
                        $display("FAIL mon_vmean ch%0d t=%0t got %0d exp %0d", c, $time, g, hold_r[c].vmean);
                    end
                end
            end
        end
    end

    task automatic test_reset();
        @(negedge Clk);
        Rst = 1'b1;
        Data_Valid = 1'b1;
        Win_Restart = 1'b1;
        Stat_Ready = 1'b1;
        ADC_IN = 32'h1234_5678;
        m_clear();
        m_sv = 1'b0;
        m_ov = 1'b0;
        exp_q.delete();
        for (int c = 0; c < CH; c++) hold_r[c] = '{0, 0, 0, 0, 0};
        repeat (3) @(posedge Clk);
        #1;
        checks++;
        if ({VMax, VMin, VMid, VMean, VPP} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got %h exp 0", {VMax, VMin, VMid, VMean, VPP});
        end
        checks++;
        if ({Stat_Valid, Overrun} !== 2'b00) begin
            failures++;
            $display("FAIL reset_flags got %b exp 00", {Stat_Valid, Overrun});
        end
        @(negedge Clk);
        Rst = 1'b0;
        Data_Valid = 1'b0;
        Win_Restart = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic test_basic();
        drive(100, 32767, 1, 0, 1);
        drive(-200, -32768, 1, 0, 1);
        drive(300, 0, 1, 0, 1);
        drive(50, 0, 1, 0, 1);
        @(posedge Clk);
        #2;
        checks++;
        if (Stat_Valid !== 1'b1) begin
            failures++;
            $display("FAIL basic_valid got %0b exp 1", Stat_Valid);
        end
        checks++;
        if ({$signed(VMax[15:0]), $signed(VMin[15:0]), $signed(VMid[15:0]), VPP[16:0], $signed(VMean[15:0])}
            !== {16'sd300, -16'sd200, 16'sd50, 17'd500, 16'sd62}) begin
            failures++;
            $display("FAIL basic_ch0 got max=%0d min=%0d mid=%0d vpp=%0d mean=%0d exp 300 -200 50 500 62",
                     $signed(VMax[15:0]), $signed(VMin[15:0]), $signed(VMid[15:0]), VPP[16:0], $signed(VMean[15:0]));
        end
        checks++;
        if ({$signed(VMid[31:16]), VPP[33:17], $signed(VMean[31:16])} !== {-16'sd1, 17'd65535, -16'sd1}) begin
            failures++;
            $display("FAIL basic_ch1 got mid=%0d vpp=%0d mean=%0d exp -1 65535 -1",
                     $signed(VMid[31:16]), VPP[33:17], $signed(VMean[31:16]));
        end
        drive(0, 0, 0, 0, 1);
    endtask

    task automatic test_all_min();
        for (int i = 0; i < 4; i++) drive(-32768, -32768, 1, 0, 1);
        @(posedge Clk);
        #2;
        checks++;
        if ({VMax[15:0], VMin[15:0], VMid[15:0], VMean[15:0], VPP[16:0]} !== {16'h8000, 16'h8000, 16'h8000, 16'h8000, 17'd0}) begin
            failures++;
            $display("FAIL allmin_ch0 got max=%h min=%h mid=%h mean=%h vpp=%0d exp 8000 x4 vpp 0",
                     VMax[15:0], VMin[15:0], VMid[15:0], VMean[15:0], VPP[16:0]);
        end
        drive(0, 0, 0, 0, 1);
    endtask

    task automatic test_restart();
        drive(50, 5, 1, 0, 1);
        drive(60, 6, 1, 0, 1);
        drive(7, 7, 1, 1, 1);
        drive(1, 1, 1, 0, 1);
        drive(1, 1, 1, 0, 1);
        drive(1, 1, 1, 0, 1);
        @(posedge Clk);
        #2;
        checks++;
        if ({Stat_Valid, $signed(VMax[15:0]), $signed(VMean[15:0])} !== {1'b1, 16'sd7, 16'sd2}) begin
            failures++;
            $display("FAIL restart_result got valid=%0b max=%0d mean=%0d exp 1 7 2",
                     Stat_Valid, $signed(VMax[15:0]), $signed(VMean[15:0]));
        end
        drive(0, 0, 0, 0, 1);
        // Restart without a sample, then a full window.
        drive(900, 900, 1, 0, 1);
        drive(0, 0, 0, 1, 1);
        for (int i = 0; i < 4; i++) drive(-3 - i, i, 1, 0, 1);
        drive(0, 0, 0, 0, 1);
    endtask

    task automatic test_gaps();
        for (int i = 0; i < 8; i++) drive(10 * (i / 2 + 1), -i, (i % 2) == 0, 0, 1);
        checks++;
        if ($signed(VMean[15:0]) !== 16'sd25) begin
            failures++;
            $display("FAIL gaps_mean got %0d exp 25", $signed(VMean[15:0]));
        end
        drive(0, 0, 0, 0, 1);
    endtask

    task automatic test_restart_on_completion();
        drive(1000, 1, 1, 0, 1);
        drive(2000, 2, 1, 0, 1);
        drive(3000, 3, 1, 0, 1);
        drive(4000, 4, 1, 1, 1);
        @(posedge Clk);
        #2;
        checks++;
        if ({Stat_Valid, $signed(VMax[15:0]), $signed(VMean[15:0])} !== {1'b1, 16'sd4000, 16'sd2500}) begin
            failures++;
            $display("FAIL restart_done got valid=%0b max=%0d mean=%0d exp 1 4000 2500",
                     Stat_Valid, $signed(VMax[15:0]), $signed(VMean[15:0]));
        end
        for (int i = 0; i < 4; i++) drive(-10, 8, 1, 0, 1);
        drive(0, 0, 0, 0, 1);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 16; i++) begin
            drive(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768, 1, 0, 1);
        end
        drive(0, 0, 0, 0, 1);
    endtask

    task automatic test_overrun();
        for (int i = 0; i < 8; i++) drive(i * 11, -i, 1, 0, 0);
        @(posedge Clk);
        #2;
        checks++;
        if ({Stat_Valid, Overrun, $signed(VMax[15:0])} !== {1'b1, 1'b1, 16'sd77}) begin
            failures++;
            $display("FAIL overrun_set got valid=%0b ovr=%0b max=%0d exp 1 1 77",
                     Stat_Valid, Overrun, $signed(VMax[15:0]));
        end
        for (int i = 0; i < 3; i++) drive(5, 5, 1, 0, 0);
        drive(9, 9, 1, 0, 1);
        @(posedge Clk);
        #2;
        checks++;
        if ({Stat_Valid, $signed(VMax[15:0])} !== {1'b1, 16'sd9}) begin
            failures++;
            $display("FAIL accept_and_load got valid=%0b max=%0d exp 1 9", Stat_Valid, $signed(VMax[15:0]));
        end
        drive(0, 0, 0, 1, 1);
        drive(0, 0, 0, 0, 1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_all_min();
        test_restart();
        test_gaps();
        test_restart_on_completion();
        test_back_to_back();
        test_overrun();
        drive(0, 0, 0, 0, 1);
        @(posedge Clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got %0d pending exp 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/adc_window_stats.md
ADC_WINDOW_STATS -- requirements
Module: adc_window_stats

Interface
REQ-001 SHALL have parameter DATA_W, default 16, sample width (signed two's complement).
REQ-002 SHALL have parameter CH_NUM, default 2, channel count (1..8).
REQ-003 SHALL have parameter WIN_LOG2, default 10, window length WIN_LEN = 2^WIN_LOG2 valid beats (1..20).
REQ-004 Clk  input  1  sole clock; all logic on rising edge.
REQ-005 Rst  input  1  reset, synchronous, active-high.
REQ-006 ADC_IN  input  CH_NUM*DATA_W  packed samples, channel n at bits [n*DATA_W +: DATA_W].
REQ-007 Data_Valid  input  1  ADC_IN valid for all channels this cycle.
REQ-008 Win_Restart  input  1  discard partial window and start a new one.
REQ-009 VMax, VMin, VMid, VMean  output  CH_NUM*DATA_W each  per-channel signed window results, same packing.
REQ-010 VPP  output  CH_NUM*(DATA_W+1)  per-channel unsigned peak-to-peak.
REQ-011 Stat_Valid  output  1  result set available; Stat_Ready  input  1  consumer accepts.
REQ-012 Overrun  output  1  sticky: an unaccepted result set was overwritten.

Function
REQ-013 Comparisons SHALL be signed over full DATA_W; running max SHALL initialise to -2^(DATA_W-1), running min to 2^(DATA_W-1)-1.
REQ-014 Each Data_Valid beat SHALL update running max, min and a signed sum (DATA_W+WIN_LOG2 bits, no overflow) for every channel, and increment one shared beat counter.
REQ-015 Beats with Data_Valid low SHALL leave all running state unchanged.
REQ-016 The beat with counter = WIN_LEN-1 SHALL be included in the window; on the next cycle outputs SHALL load the final values and Stat_Valid SHALL be 1 (latency 1 cycle after last sample).
REQ-017 On that same completion beat the running state SHALL reinitialise (REQ-013, sum 0, counter 0); the next valid beat is sample 0 of the next window, no gap.
REQ-018 VMid SHALL be (VMax+VMin) computed at DATA_W+1 bits, arithmetic-shifted right 1 (rounds toward minus infinity).
REQ-019 VPP SHALL be VMax-VMin at DATA_W+1 bits, unsigned, range 0..2^DATA_W-1.
REQ-020 VMean SHALL be sum arithmetic-shifted right WIN_LOG2 (floor).
REQ-021 Outputs SHALL hold between completions; they change only on load.
REQ-022 Handshake: set cleared when Stat_Valid and Stat_Ready both 1, unless a new load occurs the same cycle, then Stat_Valid stays 1 with new data.
REQ-023 Load while Stat_Valid=1 and Stat_Ready=0 SHALL overwrite outputs and set Overrun; Overrun clears only on Rst.
REQ-024 Win_Restart SHALL reinitialise running state and counter; outputs, Stat_Valid, Overrun unaffected.
REQ-025 Win_Restart with Data_Valid same cycle: that sample SHALL be sample 0 of the new window.
REQ-026 Win_Restart on a completion beat: completion SHALL still load results, new window starts empty.

Reset
REQ-027 Rst SHALL set all outputs 0, Stat_Valid 0, Overrun 0, counter 0, running state per REQ-013; Rst mid-window discards it.
REQ-028 Rst SHALL dominate Win_Restart, Data_Valid and Stat_Ready.

Structure
REQ-029 Package adc_acq_pkg SHALL hold default DATA_W and functions for signed min/max initial constants.
REQ-030 Per-channel max/min/sum logic SHALL be sub-module adc_ch_stats, instantiated CH_NUM times; counter, handshake and Overrun SHALL live in the top.

Verification (DATA_W=16, CH_NUM=2, WIN_LOG2=2)
REQ-031 Rst asserted 3 cycles -> all outputs 0, Stat_Valid 0, Overrun 0.
REQ-032 ch0 samples 100,-200,300,50 -> one cycle after 4th beat Stat_Valid=1, VMax=300, VMin=-200, VMid=50, VPP=500, VMean=62.
REQ-033 ch1 samples 32767,-32768,0,0 -> VMid=-1, VPP=65535, VMean=-1; all -32768 -> VMax=VMin=VMid=VMean=-32768, VPP=0.
REQ-034 2 beats, Win_Restart with 3rd beat (value 7), then 3 beats of 1 -> completion after 4 beats from restart, VMax=7, VMean=2.
REQ-035 Stat_Ready low across two windows -> second set overwrites, Overrun=1; Stat_Ready high on next completion cycle -> Stat_Valid stays 1.
REQ-036 Data_Valid toggling 1,0,1,0 for 8 cycles -> completion after 4th valid beat only.
